// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the multicycle RISC-V control path.
//   ctrl_state_t  - multicycle controller state encoding
//   OP_*          - supported major opcodes (instr[6:0])
//   ALU_*         - ALU operation select encodings, shared with the ALU
//   ALUOP_*       - controller-to-decoder ALU class select
//   imm_src_of()  - immediate format select derived from the opcode
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } ctrl_state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:     imm_src_of = IMM_S;
            OP_BRANCH: imm_src_of = IMM_B;
            OP_JAL:    imm_src_of = IMM_J;
            default:   imm_src_of = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: purely combinational ALU operation select.
//   aluop       in  2 : ALU class from the controller (add / sub / decode funct)
//   funct3      in  3 : instr[14:12]
//   op5         in  1 : instr[5], separates R-type from I-type
//   funct7b5    in  1 : instr[30]
//   alu_control out 3 : ALU operation select
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    // addi has funct7b5 as an immediate bit, so sub also needs op[5]
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle RISC-V datapath.
// Sequences fetch / decode / execute / memory / writeback and drives every
// datapath enable and mux select plus the ALU operation select.
//   clk, reset (async, active-high; forces all outputs to 0 while high)
//   op, funct3, funct7b5 : instruction fields from the IR
//   zero                 : ALU zero flag, only consulted in the BEQ state
//   pc_write, adr_src, mem_write, ir_write, reg_write : enables / selects
//   result_src, alu_src_a, alu_src_b, imm_src, alu_control : mux selects
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (funct3=001 becomes bne).
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control
);

    ctrl_state_t state, state_nxt;

    logic       pc_update, branch, branch_taken;
    logic       adr_src_s, mem_write_s, ir_write_s, reg_write_s;
    logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, aluop;
    logic [2:0] alu_control_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECR;
                    OP_ITYPE:     state_nxt = S_EXECI;
                    OP_BRANCH:    state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_FETCH;  // unsupported: NOP
                endcase
            end
            S_MEMADR:  state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_nxt = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: state_nxt = S_ALUWB;
            default:   state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update    = 1'b0;
        branch       = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        aluop        = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                // PC+4 computed in the ALU and routed straight back to the PC
                ir_write_s   = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                pc_update    = 1'b1;
            end
            S_DECODE: begin
                // old PC + B-immediate, held in ALUOut for a taken branch
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_MEMREAD: adr_src_s = 1'b1;
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_s = 2'b10;
                aluop       = ALUOP_FUNC;
            end
            S_EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                aluop       = ALUOP_FUNC;
            end
            S_ALUWB: reg_write_s = 1'b1;
            S_BEQ: begin
                alu_src_a_s = 2'b10;
                aluop       = ALUOP_SUB;
                branch      = 1'b1;
            end
            S_JAL: begin
                // rd <= old PC + 4 via ALU, PC <= jump target from ALUOut
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000: branch_taken = zero;
`ifdef MULTICYCLE_CTRL_BNE_EN
            3'b001: branch_taken = ~zero;
`else
            3'b001: branch_taken = 1'b0;
`endif
            default: branch_taken = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control_s)
    );

    // Reset gates everything so no stray enable reaches the datapath while
    // an aborted instruction's state is being discarded.
    assign pc_write    = ~reset & (pc_update | (branch & branch_taken));
    assign adr_src     = ~reset & adr_src_s;
    assign mem_write   = ~reset & mem_write_s;
    assign ir_write    = ~reset & ir_write_s;
    assign reg_write   = ~reset & reg_write_s;
    assign result_src  = reset ? 2'b00 : result_src_s;
    assign alu_src_a   = reset ? 2'b00 : alu_src_a_s;
    assign alu_src_b   = reset ? 2'b00 : alu_src_b_s;
    assign imm_src     = reset ? 2'b00 : imm_src_of(op);
    assign alu_control = reset ? 3'b000 : alu_control_s;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process pushes one
// expected output word per cycle of each instruction; a monitor process
// pops and compares at every falling edge.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] v;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0;
    bit   mon_en = 1'b0;

    wire logic [15:0] dut_v = {pc_write, adr_src, mem_write, ir_write, reg_write,
                               result_src, alu_src_a, alu_src_b, imm_src, alu_control};

    // ---------------- reference model (from the instruction semantics) ----
    function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'd0:    return (o[5] && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input logic z);
        if (f3 == 3'd0) return z;
`ifdef MULTICYCLE_CTRL_BNE_EN
        if (f3 == 3'd1) return !z;
`endif
        return 1'b0;
    endfunction

    // Steps an instruction walks through, by opcode.
    function automatic int n_steps(input logic [6:0] o);
        case (o)
            7'b0000011: return 5;
            7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
            7'b1100011: return 3;
            default:    return 2;
        endcase
    endfunction

    function automatic string step_name(input logic [6:0] o, input int k);
        if (k == 0) return "FETCH";
        if (k == 1) return "DECODE";
        case (o)
            7'b0000011: return (k == 2) ? "MEMADR" : (k == 3) ? "MEMREAD" : "MEMWB";
            7'b0100011: return (k == 2) ? "MEMADR" : "MEMWRITE";
            7'b0110011: return (k == 2) ? "EXECR" : "ALUWB";
            7'b0010011: return (k == 2) ? "EXECI" : "ALUWB";
            7'b1101111: return (k == 2) ? "JAL" : "ALUWB";
            default:    return "BEQ";
        endcase
    endfunction

    function automatic logic [15:0] ref_out(input string s, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7,
                                            input logic z);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0;
        logic [2:0] alu = 3'b000;
        case (s)
            "FETCH":    begin irw = 1; sb = 2'b10; rs = 2'b10; pcw = 1; end
            "DECODE":   begin sa = 2'b01; sb = 2'b01; end
            "MEMADR":   begin sa = 2'b10; sb = 2'b01; end
            "MEMREAD":  adr = 1;
            "MEMWRITE": begin adr = 1; mw = 1; end
            "MEMWB":    begin rs = 2'b01; rw = 1; end
            "EXECR":    begin sa = 2'b10; alu = ref_alu(o, f3, f7); end
            "EXECI":    begin sa = 2'b10; sb = 2'b01; alu = ref_alu(o, f3, f7); end
            "ALUWB":    rw = 1;
            "BEQ":      begin sa = 2'b10; alu = 3'b001; pcw = ref_taken(f3, z); end
            "JAL":      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {pcw, adr, mw, irw, rw, rs, sa, sb, ref_imm(o), alu};
    endfunction

    // ---------------- monitor ----------------------------------------------
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            exp_t e;
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL underflow: DUT active with no expected entry, got %h", dut_v);
            end else begin
                e = q.pop_front();
                if (dut_v !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %b required %b", e.name, dut_v, e.v);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", nm, got, req);
        end
    endtask

    // Drive one instruction: push all expected cycles, then step through them.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode);  // zmode: 0/1 forced, 2 random
        int n = n_steps(o);
        logic z[5];
        for (int k = 0; k < n; k++) begin
            z[k] = (zmode == 2) ? 1'($urandom_range(1)) : 1'(zmode);
            q.push_back('{$sformatf("%s op=%b f3=%0d", step_name(o, k), o, f3),
                          ref_out(step_name(o, k), o, f3, f7, z[k])});
        end
        op = o; funct3 = f3; funct7b5 = f7;
        for (int k = 0; k < n; k++) begin
            zero = z[k];
            @(posedge clk); #1;
        end
    endtask

    logic [6:0] ops [7];

    initial begin
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1110011};
        reset = 1'b1; op = 7'b0000011; funct3 = 0; funct7b5 = 0; zero = 0;
        @(negedge clk);
        check("reset_outputs_zero", dut_v, 16'h0000);

        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // directed cases
        run_instr(7'b0000011, 3'd2, 1'b0, 2);   // lw
        run_instr(7'b0110011, 3'd0, 1'b1, 2);   // R sub
        run_instr(7'b0010011, 3'd0, 1'b1, 2);   // addi, never sub
        run_instr(7'b1100011, 3'd0, 1'b0, 1);   // beq taken
        run_instr(7'b1100011, 3'd0, 1'b0, 0);   // beq not taken
        run_instr(7'b1100011, 3'd1, 1'b0, 0);   // funct3=001, zero=0
        run_instr(7'b1100011, 3'd1, 1'b0, 1);
        run_instr(7'b1110011, 3'd0, 1'b0, 2);   // unsupported -> NOP
        run_instr(7'b0100011, 3'd2, 1'b0, 2);   // sw
        run_instr(7'b1101111, 3'd0, 1'b0, 2);   // jal
        for (int f = 0; f < 8; f++) run_instr(7'b0110011, 3'(f), 1'($urandom_range(1)), 2);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [6:0] o;
            if ($urandom_range(9) == 0) o = 7'($urandom);
            else                        o = ops[$urandom_range(6)];
            run_instr(o, 3'($urandom), 1'($urandom), 2);
        end

        mon_en = 1'b0;
        check("scoreboard_drained", 16'(q.size()), 16'd0);

        // reset mid-MEMREAD: FETCH, DECODE, MEMADR, then abort in MEMREAD
        op = 7'b0000011; funct3 = 3'd2; zero = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("memread_adr_src", {15'd0, adr_src}, 16'd1);
        #1 reset = 1'b1;
        #1 check("reset_async_zero", dut_v, 16'h0000);
        @(negedge clk);
        check("reset_held_zero", dut_v, 16'h0000);
        @(posedge clk); #1;
        check("reset_across_edge_zero", dut_v, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_fetch", {13'd0, ir_write, alu_src_b[1], pc_write}, 16'b111);
        check("post_reset_fetch_full", dut_v, ref_out("FETCH", 7'b0000011, 3'd2, 1'b0, 1'b0));
        @(posedge clk); #1;
        check("post_reset_decode", dut_v, ref_out("DECODE", 7'b0000011, 3'd2, 1'b0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control unit for the multicycle RISC-V datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback, and drives the ALU's 3-bit operation select. It reads the opcode/funct fields from the instruction register and the ALU `zero` flag. It drives every datapath enable and mux select. It is the issuing end of the ALU control interface.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `op` in 7: instr[6:0].
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU result-equals-zero flag.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select; 0=PC, 1=result.
- `mem_write` out 1: data memory write enable.
- `ir_write` out 1: instruction/old-PC register enable.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result select; 00=ALUOut, 01=data, 10=ALU result.
- `alu_src_a` out 2: ALU A select; 00=PC, 01=old PC, 10=rs1.
- `alu_src_b` out 2: ALU B select; 00=rs2, 01=imm, 10=constant 4.
- `imm_src` out 2: immediate format; 00=I, 01=S, 10=B, 11=J.
- `alu_control` out 3: add 000, sub 001, and 010, or 011, slt 101.

## Operation
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-type ALU 0010011
  - branch 1100011
  - jal 1101111
- States and transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), EXECR (R), EXECI (I), BEQ (branch), JAL (jal). Any other opcode→FETCH, executed as a NOP.
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB.
  - MEMWB, MEMWRITE and BEQ→FETCH.
  - EXECR, EXECI and JAL→ALUWB.
  - ALUWB→FETCH.
- State outputs. Unlisted signals are 0. `aluop` is internal: 00=add, 01=sub, 10=decode funct.
  - FETCH: adr_src 0, ir_write 1, src_a 00, src_b 10, aluop 00, result_src 10, pc_update 1.
  - DECODE: src_a 01, src_b 01, aluop 00 (branch target precompute).
  - MEMADR: src_a 10, src_b 01, aluop 00.
  - MEMREAD: result_src 00, adr_src 1.
  - MEMWRITE: result_src 00, adr_src 1, mem_write 1.
  - MEMWB: result_src 01, reg_write 1.
  - EXECR: src_a 10, src_b 00, aluop 10.
  - EXECI: src_a 10, src_b 01, aluop 10.
  - ALUWB: result_src 00, reg_write 1.
  - BEQ: src_a 10, src_b 00, aluop 01, result_src 00, branch 1.
  - JAL: src_a 01, src_b 10, aluop 00, result_src 00, pc_update 1.
- `pc_write = pc_update | (branch & branch_taken)`.
  - Base build: `branch_taken = zero`, used only when funct3=000. Any other funct3 gives `branch_taken = 0`.
- `imm_src` is combinational from `op` in every state: lw/I-type 00, sw 01, branch 10, jal 11, other 00.
- ALU decode (aluop=10), by funct3:
  - 000: sub when op[5]&funct7b5, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3: add.
- I-type never selects sub, because op[5]=0.

## Timing
- `reset` is asynchronous. State goes to FETCH immediately on assertion.
- While `reset` is high, every output is forced to 0. This includes `pc_write` and `ir_write`.
- The first edge after reset deasserts performs FETCH.
- Reset asserted mid-instruction aborts it. No further write enables are driven.
- Outputs are purely combinational from the current state, plus `zero` for `pc_write`. They are valid within the same cycle.
- Instruction latency in cycles: lw 5; sw 4; R 4; I 4; branch 3; jal 4; illegal 2.
- `zero` is sampled only in BEQ. Its value in other states has no effect.

## Configuration
- `MULTICYCLE_CTRL_BNE_EN` defined: funct3=001 is bne, with `branch_taken = ~zero`. beq behaviour is unchanged.
- Macro undefined: funct3=001 is a non-taken branch. It completes in 3 cycles with `pc_write` 0 in BEQ.

## Structure
- Shared package `riscv_pkg` holds:
  - the state enum `ctrl_state_t`;
  - the opcode localparams;
  - the ALU encoding localparams. The ALU uses these same constants.
- Sub-module `alu_decoder` maps (aluop, funct3, op[5], funct7b5) to `alu_control`. It is purely combinational.
- The FSM register and output decode live in `multicycle_ctrl`.

## Test plan
- Reset assert mid-MEMREAD, then release:
  - outputs are all 0 immediately;
  - the first post-release cycle has ir_write=1, src_b=10, pc_write=1.
- lw (op 0000011) sequence:
  - 5 cycles in the order FETCH, DECODE, MEMADR, MEMREAD, MEMWB;
  - reg_write=1, result_src=01 only in cycle 5.
- R-type sub (funct3 000, funct7b5 1): alu_control=001 in EXECR; ALUWB reg_write=1; 4 cycles.
- I-type (op 0010011, funct7b5 1, funct3 000): alu_control=000, not sub.
- beq with zero=1 gives pc_write=1 in BEQ; with zero=0, pc_write=0; 3 cycles each.
- funct3=001 branch with zero=0 gives pc_write=1 only with `MULTICYCLE_CTRL_BNE_EN`. Also: op 1110011 returns to FETCH after DECODE, with no write enables.
